dmem_wait_responder: RTL and testbench
======================================

// Module: dmem_wait_responder
// PURPOSE
//  Data-memory responder that sits on the processor's data bus (address, write data, write enable, read data).
//  Unlike the zero-latency dmem, it adds a req/ready handshake with a programmable number of wait states.
//  It also flags misaligned and out-of-range accesses.
//  Used to exercise a stalling datapath, and as the bus endpoint for multicycle/pipelined cores.
// PARAMETERS
//  DEPTH    64  number of 32-bit words; legal byte addresses 0 .. 4*DEPTH-4
//  LATENCY  2   wait-state cycles between acceptance and response, 0..15
// PORTS
//  clk    in   1   rising-edge clock
//  reset  in   1   synchronous, active-high reset
//  req    in   1   request valid; sampled only in IDLE
//  we     in   1   1 = write, 0 = read; captured with req
//  a      in   32  byte address; captured with req
//  wd     in   32  write data; captured with req
//  rd     out  32  read data; valid while ready=1
//  ready  out  1   one-cycle response pulse
//  err    out  1   error flag; valid while ready=1
// BEHAVIOUR
//  Interface and reset:
//  - One clock. Reset is synchronous and active-high.
//  - Reset values: state=IDLE, ready=0, err=0, rd=0, wait counter=0.
//  - RAM contents are NOT reset.
//  State machine (IDLE, WAIT, RESP):
//  - IDLE: if req=1, register we, a and wd, and load the counter with LATENCY.
//    - Next state is WAIT when LATENCY>0, RESP when LATENCY=0.
//  - WAIT: decrement the counter each cycle; go to RESP on the edge where the counter reaches 0.
//    - req, we, a and wd are ignored in WAIT; only captured copies are used.
//  - RESP: ready=1 for exactly this cycle, then return to IDLE unconditionally.
//  Timing:
//  - A request accepted at edge N drives ready=1 during cycle N+1+LATENCY.
//  - req is not sampled in RESP. If req is still high in the following IDLE cycle, it is a NEW request.
//  - Maximum throughput is one access per LATENCY+2 cycles.
//  Address check (on the captured address):
//  - err = (a[1:0]!=0) | (a[31:2] >= DEPTH).
//  - err is driven in the RESP cycle only; 0 otherwise.
//  Read (captured we=0):
//  - rd is registered from RAM[a[31:2]] on entry to RESP.
//  - rd holds its value after RESP until the next response.
//  - On err, rd=0.
//  Write (captured we=1):
//  - RAM[a[31:2]] <= wd at the edge that enters RESP; rd=0 in the RESP cycle.
//  - On err, no RAM location is modified.
//  - A read issued after the write's ready pulse returns the new data.
//  Reset mid-operation:
//  - Reset in WAIT or RESP forces IDLE and ready=0, err=0, rd=0.
//  - A pending write that has not yet entered RESP is discarded.
//  - A write whose RESP entry coincides with the reset edge is also discarded.
//  Widths:
//  - The counter is 4 bits.
//  - Index compare uses the full a[31:2], so large addresses never alias into the RAM.
// TESTING
//  1. LATENCY=2: write a=100 wd=7, req accepted at edge 0.
//     -> ready=1, err=0 in cycle 3 only.
//     -> Then read a=100 -> ready 3 cycles after acceptance, rd=7.
//  2. LATENCY=0: write a=96 wd=32'h1234 then read a=96.
//     -> Each ready arrives in the cycle after acceptance; read rd=32'h1234.
//  3. Misaligned write a=102 wd=5 -> ready=1, err=1.
//     -> Then read a=100 -> rd=7 (RAM unchanged), err=0.
//  4. DEPTH=64: read a=256 and write a=32'hFFFF_FFFC.
//     -> Both give err=1; the read gives rd=0.
//     -> No word 0..63 changes; verify by reading back all words.
//  5. Write a=96 wd=9 with LATENCY=3; assert reset for 1 cycle during WAIT.
//     -> No ready pulse, outputs go to 0.
//     -> A subsequent read of a=96 returns the old value.
//  6. Hold req=1 continuously with a=100, and change a/wd while in WAIT.
//     -> Responses use the captured values.
//     -> A new acceptance occurs in the cycle after each ready pulse (period LATENCY+2).

Source files
------------

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: word RAM behind a req/ready handshake with programmable wait states and access-error flagging
module dmem_wait_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        ready,
   output logic        err
);
   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
   localparam logic [3:0]  LAT_W   = 4'(LATENCY);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t        r_state;
   logic [3:0]    r_cnt;
   logic          r_we;
   logic [31:0]   r_a;
   logic [31:0]   r_wd;
   logic [31:0]   r_mem [DEPTH];
   logic          w_idle_go;
   logic          w_enter;
   logic          w_we;
   logic          w_err;
   logic [31:0]   w_a;
   logic [31:0]   w_wd;
   logic [AW-1:0] w_idx;
   // zero-latency requests resolve straight from the bus; otherwise the captured copy drives the access
   always_comb begin
      w_idle_go = (r_state == IDLE) && req;
      w_enter   = (w_idle_go && LAT_W == 4'd0) || (r_state == WAIT && r_cnt == 4'd1);
      w_we      = w_idle_go ? we : r_we;
      w_a       = w_idle_go ? a : r_a;
      w_wd      = w_idle_go ? wd : r_wd;
      w_err     = (w_a[1:0] != 2'b00) || ({2'b00, w_a[31:2]} >= DEPTH_W);
      w_idx     = w_a[AW+1:2];
   end
   // handshake FSM; ready/err/rd are registered on the edge that enters RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_a     <= 32'd0;
         r_wd    <= 32'd0;
         ready   <= 1'b0;
         err     <= 1'b0;
         rd      <= 32'd0;
      end else begin
         ready <= w_enter;
         err   <= w_enter && w_err;
         if (w_enter) rd <= (!w_we && !w_err) ? r_mem[w_idx] : 32'd0;
         case (r_state)
            IDLE: if (req) begin
               r_we    <= we;
               r_a     <= a;
               r_wd    <= wd;
               r_cnt   <= LAT_W;
               r_state <= (LAT_W == 4'd0) ? RESP : WAIT;
            end
            WAIT: begin
               r_cnt   <= r_cnt - 4'd1;
               r_state <= (r_cnt == 4'd1) ? RESP : WAIT;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   // RAM is never reset; a write commits only on a clean RESP entry with a legal address
   always_ff @(posedge clk) begin
      if (!reset && w_enter && w_we && !w_err) r_mem[w_idx] <= w_wd;
   end
endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb_dmem_wait_responder: randomized bench for three latency variants against a word-array reference model
module tb_dmem_wait_responder;
   localparam int LAT [3] = '{2, 0, 3};
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req [3];
   logic        we [3];
   logic [31:0] a [3];
   logic [31:0] wd [3];
   logic [31:0] rd [3];
   logic        ready [3];
   logic        err [3];
   logic [31:0] mdl [3][64];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   dmem_wait_responder #(.DEPTH(64), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .req(req[0]), .we(we[0]),
      .a(a[0]), .wd(wd[0]), .rd(rd[0]), .ready(ready[0]), .err(err[0]));
   dmem_wait_responder #(.DEPTH(64), .LATENCY(0)) u_l0 (.clk(clk), .reset(reset), .req(req[1]), .we(we[1]),
      .a(a[1]), .wd(wd[1]), .rd(rd[1]), .ready(ready[1]), .err(err[1]));
   dmem_wait_responder #(.DEPTH(64), .LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .req(req[2]), .we(we[2]),
      .a(a[2]), .wd(wd[2]), .rd(rd[2]), .ready(ready[2]), .err(err[2]));

   function automatic logic bad_addr(input logic [31:0] addr);
      return (addr % 4 != 0) || (addr / 4 >= 64);
   endfunction

   // one bus access; reports the response and how many cycles after acceptance ready appeared (0 = never)
   task automatic access(input int d, input logic w, input logic [31:0] addr, input logic [31:0] dat,
                         output logic [31:0] ord, output logic oerr, output int olat, output logic ostray);
      @(negedge clk);
      req[d] = 1'b1; we[d] = w; a[d] = addr; wd[d] = dat;
      @(posedge clk);
      #1;
      req[d] = 1'b0; we[d] = 1'($urandom); a[d] = $urandom; wd[d] = $urandom;
      olat = 0; ord = 32'hx; oerr = 1'bx; ostray = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (ready[d]) begin
            olat = i; ord = rd[d]; oerr = err[d];
            break;
         end
      end
      @(negedge clk);
      ostray = ready[d];
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if (ready[d] !== 1'b0 || err[d] !== 1'b0 || rd[d] !== 32'd0) begin
            miscompares++;
            $display("FAIL reset dut%0d: ready=%b err=%b rd=%h, want 0 0 0", d, ready[d], err[d], rd[d]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_fill;
      logic [31:0] r; logic e; int l; logic s;
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 64; i++) begin
            mdl[d][i] = $urandom;
            access(d, 1'b1, 32'(i * 4), mdl[d][i], r, e, l, s);
            vectors++;
            if (e !== 1'b0 || l != LAT[d] + 1) begin
               miscompares++;
               $display("FAIL fill dut%0d word %0d: err=%b lat=%0d, want 0 %0d", d, i, e, l, LAT[d] + 1);
            end
         end
   endtask

   task automatic test_basic;
      logic [31:0] r; logic e; int l; logic s;
      access(0, 1'b1, 32'd100, 32'd7, r, e, l, s);
      mdl[0][25] = 32'd7;
      vectors++;
      if (l != 3 || e !== 1'b0 || r !== 32'd0 || s !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_write: lat=%0d err=%b rd=%h stray=%b, want 3 0 0 0", l, e, r, s);
      end
      access(0, 1'b0, 32'd100, 32'd0, r, e, l, s);
      vectors++;
      if (l != 3 || e !== 1'b0 || r !== 32'd7 || s !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_read: lat=%0d err=%b rd=%h stray=%b, want 3 0 7 0", l, e, r, s);
      end
   endtask

   task automatic test_zero_latency;
      logic [31:0] r; logic e; int l; logic s;
      access(1, 1'b1, 32'd96, 32'h1234, r, e, l, s);
      mdl[1][24] = 32'h1234;
      vectors++;
      if (l != 1 || e !== 1'b0 || s !== 1'b0) begin
         miscompares++;
         $display("FAIL lat0_write: lat=%0d err=%b stray=%b, want 1 0 0", l, e, s);
      end
      access(1, 1'b0, 32'd96, 32'd0, r, e, l, s);
      vectors++;
      if (l != 1 || e !== 1'b0 || r !== 32'h1234) begin
         miscompares++;
         $display("FAIL lat0_read: lat=%0d err=%b rd=%h, want 1 0 1234", l, e, r);
      end
   endtask

   task automatic test_misaligned;
      logic [31:0] r; logic e; int l; logic s;
      access(0, 1'b1, 32'd102, 32'd5, r, e, l, s);
      vectors++;
      if (l != 3 || e !== 1'b1) begin
         miscompares++;
         $display("FAIL misaligned_write: lat=%0d err=%b, want 3 1", l, e);
      end
      access(0, 1'b0, 32'd101, 32'd0, r, e, l, s);
      vectors++;
      if (e !== 1'b1 || r !== 32'd0) begin
         miscompares++;
         $display("FAIL misaligned_read: err=%b rd=%h, want 1 0", e, r);
      end
      access(0, 1'b0, 32'd100, 32'd0, r, e, l, s);
      vectors++;
      if (e !== 1'b0 || r !== 32'd7) begin
         miscompares++;
         $display("FAIL misaligned_unchanged: err=%b rd=%h, want 0 7", e, r);
      end
   endtask

   task automatic test_out_of_range;
      logic [31:0] r; logic e; int l; logic s;
      access(0, 1'b0, 32'd256, 32'd0, r, e, l, s);
      vectors++;
      if (e !== 1'b1 || r !== 32'd0 || l != 3) begin
         miscompares++;
         $display("FAIL oor_read: err=%b rd=%h lat=%0d, want 1 0 3", e, r, l);
      end
      access(0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, r, e, l, s);
      vectors++;
      if (e !== 1'b1) begin
         miscompares++;
         $display("FAIL oor_write: err=%b, want 1", e);
      end
      for (int i = 0; i < 64; i++) begin
         access(0, 1'b0, 32'(i * 4), 32'd0, r, e, l, s);
         vectors++;
         if (r !== mdl[0][i] || e !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_readback word %0d: rd=%h err=%b, want %h 0", i, r, e, mdl[0][i]);
         end
      end
   endtask

   task automatic test_reset_wait;
      logic [31:0] r; logic e; int l; logic s; logic seen;
      access(2, 1'b0, 32'd96, 32'd0, r, e, l, s);
      vectors++;
      if (r !== mdl[2][24]) begin
         miscompares++;
         $display("FAIL rstwait_pre: rd=%h, want %h", r, mdl[2][24]);
      end
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; a[2] = 32'd96; wd[2] = 32'd9;
      @(posedge clk);
      #1 req[2] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (ready[2] !== 1'b0 || err[2] !== 1'b0 || rd[2] !== 32'd0) begin
         miscompares++;
         $display("FAIL rstwait_outputs: ready=%b err=%b rd=%h, want 0 0 0", ready[2], err[2], rd[2]);
      end
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ready[2]) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL rstwait_no_ready: ready seen=%b, want 0", seen);
      end
      access(2, 1'b0, 32'd96, 32'd0, r, e, l, s);
      vectors++;
      if (r !== mdl[2][24] || l != 4) begin
         miscompares++;
         $display("FAIL rstwait_old_value: rd=%h lat=%0d, want %h 4", r, l, mdl[2][24]);
      end
   endtask

   task automatic test_reset_at_resp;
      logic [31:0] r; logic e; int l; logic s;
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; a[2] = 32'd96; wd[2] = 32'hDEAD_0001;
      @(posedge clk);
      #1 req[2] = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (ready[2] !== 1'b0 || rd[2] !== 32'd0) begin
         miscompares++;
         $display("FAIL rstresp_outputs: ready=%b rd=%h, want 0 0", ready[2], rd[2]);
      end
      access(2, 1'b0, 32'd96, 32'd0, r, e, l, s);
      vectors++;
      if (r !== mdl[2][24]) begin
         miscompares++;
         $display("FAIL rstresp_discarded: rd=%h, want %h", r, mdl[2][24]);
      end
   endtask

   task automatic test_back_to_back;
      int p; logic [31:0] cap;
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b0; a[0] = 32'd100; wd[0] = $urandom;
      cap = a[0];
      @(posedge clk);
      p = 0;
      repeat (30) begin
         @(negedge clk);
         vectors++;
         if (ready[0] !== (p == LAT[0])) begin
            miscompares++;
            $display("FAIL b2b_ready phase %0d: ready=%b, want %b", p, ready[0], p == LAT[0]);
         end
         if (p == LAT[0]) begin
            vectors++;
            if (rd[0] !== mdl[0][cap / 4] || err[0] !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_data a=%0d: rd=%h err=%b, want %h 0", cap, rd[0], err[0], mdl[0][cap / 4]);
            end
         end
         a[0] = 32'($urandom_range(0, 63)) * 4;
         wd[0] = $urandom;
         if (p == LAT[0] + 1) cap = a[0];
         @(posedge clk);
         p = (p == LAT[0] + 1) ? 0 : p + 1;
      end
      @(negedge clk);
      req[0] = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_random;
      logic [31:0] r; logic e; int l; logic s; int d; logic w; logic [31:0] addr; logic [31:0] dat;
      logic ee; logic [31:0] er; int sel;
      repeat (80) begin
         d = $urandom_range(0, 2);
         w = 1'($urandom);
         dat = $urandom;
         sel = $urandom_range(0, 9);
         addr = (sel < 7) ? 32'($urandom_range(0, 63)) * 4 :
                (sel == 7) ? 32'($urandom_range(0, 255)) :
                (sel == 8) ? 32'($urandom_range(64, 1000)) * 4 : $urandom;
         ee = bad_addr(addr);
         er = (w || ee) ? 32'd0 : mdl[d][addr / 4];
         access(d, w, addr, dat, r, e, l, s);
         if (w && !ee) mdl[d][addr / 4] = dat;
         vectors++;
         if (r !== er || e !== ee || l != LAT[d] + 1 || s !== 1'b0) begin
            miscompares++;
            $display("FAIL random dut%0d we=%b a=%h: rd=%h err=%b lat=%0d stray=%b, want %h %b %0d 0",
                     d, w, addr, r, e, l, s, er, ee, LAT[d] + 1);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; a[d] = 32'd0; wd[d] = 32'd0;
      end
      test_reset;
      test_fill;
      test_basic;
      test_zero_latency;
      test_misaligned;
      test_out_of_range;
      test_reset_wait;
      test_reset_at_resp;
      test_back_to_back;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
      $fatal(1, "watchdog expired");
   end
endmodule
